seq_bit_serializer: RTL and testbench

- Parallel-to-serial front end that generates the single-bit stream `x` consumed by the sequence-detector FSMs (101 Mealy/Moore family).
- Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one bit per clock.
- A one-word holding buffer lets consecutive words stream with no idle gap.
- Serves as a stimulus and data source for detector stages in both RTL and benches.

---
 rtl/seq_ser_pkg.sv | 17 +
 rtl/seq_bit_serializer.sv | 108 ++++++++++
 tb/tb_seq_bit_serializer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_ser_pkg.sv
// Shared types and helpers for the parallel-to-serial bit source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_ser_pkg;

  // Serializer control state: waiting for a word, or shifting one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Bit-index counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in, one registered bit per clock out.
// Latency: word accepted at edge N drives bit 0 after edge N; bit k after edge N+k.
// Backpressure: din_ready = !hold_full; one word can wait in the holding buffer, gapless hand-off.
module seq_bit_serializer
  import seq_ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;      // bits still to be sent after the one on x
  logic [WIDTH-1:0] hold_buf;
  logic             hold_full;
  logic [CW-1:0]    cnt;        // index of the bit currently on x

  logic             accept;
  logic             last_bit;
  logic             load;
  logic [WIDTH-1:0] load_word;

  // The bit that leaves first, given the configured order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the bit just sent so the next one sits in the first-bit position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready depends only on the buffer register, never on din_valid.
  assign din_ready = !hold_full;
  assign accept    = din_valid && din_ready;
  assign last_bit  = (state == SHIFT) && (cnt == LAST);
  assign busy      = (state == SHIFT) || hold_full;

  // Pick the next word to start: buffered word has priority over a fresh one.
  always_comb begin
    load      = 1'b0;
    load_word = din;
    if (state == IDLE) begin
      load = accept;
    end else if (last_bit) begin
      load = hold_full || accept;
      if (hold_full) begin
        load_word = hold_buf;
      end
    end
  end

  // Control FSM with registered serial outputs, shift register and counter.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      shreg       <= '0;
      hold_buf    <= '0;
      hold_full   <= 1'b0;
      cnt         <= '0;
      x           <= IDLE_BIT;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (load) begin
        state       <= SHIFT;
        x           <= first_bit(load_word);
        shreg       <= advance(load_word);
        cnt         <= '0;
        x_valid     <= 1'b1;
        frame_start <= 1'b1;
      end else if (state == SHIFT && !last_bit) begin
        x           <= first_bit(shreg);
        shreg       <= advance(shreg);
        cnt         <= cnt + 1'b1;
        frame_start <= 1'b0;
      end else begin
        state       <= IDLE;
        x           <= IDLE_BIT;
        x_valid     <= 1'b0;
        frame_start <= 1'b0;
        cnt         <= '0;
      end

      // A word arriving mid-frame parks in the buffer until the last-bit edge.
      if (state == SHIFT && !last_bit && accept) begin
        hold_buf  <= din;
        hold_full <= 1'b1;
      end else if (last_bit && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for two serializer configurations sharing one clock and reset.
// A: WIDTH=3, MSB first, idle 0.  B: WIDTH=8, LSB first, idle 1.
// Expected bit streams come from word bit-order rules; the monitor pops one per valid cycle.
module tb_seq_bit_serializer;

  localparam int WA     = 3;
  localparam int WB     = 8;
  localparam bit IDLE_A = 1'b0;
  localparam bit IDLE_B = 1'b1;

  logic clk    = 1'b0;
  logic areset = 1'b1;

  logic [WA-1:0] din_a;
  logic          din_valid_a, din_ready_a, x_a, x_valid_a, frame_start_a, busy_a;
  logic [WB-1:0] din_b;
  logic          din_valid_b, din_ready_b, x_b, x_valid_b, frame_start_b, busy_b;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(WA), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_A)) dut_a (
    .clk(clk), .areset(areset), .din(din_a), .din_valid(din_valid_a),
    .din_ready(din_ready_a), .x(x_a), .x_valid(x_valid_a),
    .frame_start(frame_start_a), .busy(busy_a)
  );

  seq_bit_serializer #(.WIDTH(WB), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_B)) dut_b (
    .clk(clk), .areset(areset), .din(din_b), .din_valid(din_valid_b),
    .din_ready(din_ready_b), .x(x_b), .x_valid(x_valid_b),
    .frame_start(frame_start_b), .busy(busy_b)
  );

  typedef struct packed {
    logic b;
    logic fs;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word becomes WIDTH bits in wire order, first one flagged.
  task automatic push_word(input int d, input logic [7:0] w);
    int   wd;
    bit   msb;
    exp_t e;
    wd  = (d == 0) ? WA : WB;
    msb = (d == 0);
    for (int i = 0; i < wd; i++) begin
      int idx;
      idx  = msb ? (wd - 1 - i) : i;
      e.b  = w[idx];
      e.fs = (i == 0);
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
  endtask

  // Per-cycle monitor check against the expected stream.
  task automatic mon(input int d, input string tag, input logic xv, input logic xb,
                     input logic fs, input logic rdy, input logic bz);
    exp_t e;
    logic ev;
    logic idle_bit;
    int   sz;
    int   wd;
    idle_bit = (d == 0) ? IDLE_A : IDLE_B;
    wd       = (d == 0) ? WA : WB;
    if (areset) begin
      chk($sformatf("%s_rst_x", tag), xb, idle_bit);
      chk($sformatf("%s_rst_x_valid", tag), xv, 1'b0);
      chk($sformatf("%s_rst_frame_start", tag), fs, 1'b0);
      chk($sformatf("%s_rst_din_ready", tag), rdy, 1'b1);
      chk($sformatf("%s_rst_busy", tag), bz, 1'b0);
      return;
    end
    sz = (d == 0) ? q_a.size() : q_b.size();
    ev = (sz > 0);
    chk($sformatf("%s_x_valid", tag), xv, ev);
    chk($sformatf("%s_busy", tag), bz, ev);
    if (ev) begin
      if (d == 0) e = q_a.pop_front();
      else        e = q_b.pop_front();
      sz--;
      chk($sformatf("%s_x", tag), xb, e.b);
      chk($sformatf("%s_frame_start", tag), fs, e.fs);
    end else begin
      chk($sformatf("%s_idle_x", tag), xb, idle_bit);
      chk($sformatf("%s_idle_frame_start", tag), fs, 1'b0);
    end
    // Remaining bits beyond the current word imply a buffered word.
    chk($sformatf("%s_din_ready", tag), rdy, (sz < wd));
  endtask

  always @(negedge clk) begin
    mon(0, "a", x_valid_a, x_a, frame_start_a, din_ready_a, busy_a);
    mon(1, "b", x_valid_b, x_b, frame_start_b, din_ready_b, busy_b);
  end

  // Offer a word and keep din_valid high until it is taken; called at posedge+1.
  task automatic send(input int d, input logic [7:0] w);
    logic acc;
    int   t;
    if (d == 0) begin
      din_a       = w[WA-1:0];
      din_valid_a = 1'b1;
    end else begin
      din_b       = w;
      din_valid_b = 1'b1;
    end
    acc = 1'b0;
    t   = 0;
    while (!acc) begin
      @(negedge clk);
      #1;
      acc = (d == 0) ? din_ready_a : din_ready_b;
      @(posedge clk);
      if (acc) push_word(d, w);
      #1;
      t++;
      if (!acc && t > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: dut %0d never ready, word %h", d, w);
        return;
      end
    end
  endtask

  // Drop valid for n cycles while wiggling din, which must be ignored.
  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      if (d == 0) begin
        din_valid_a = 1'b0;
        din_a       = WA'($urandom);
      end else begin
        din_valid_b = 1'b0;
        din_b       = WB'($urandom);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_run(input int d);
    for (int i = 0; i < 30; i++) begin
      send(d, 8'($urandom));
      if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(1, 4));
    end
    idle(d, 1);
  endtask

  initial begin
    din_a       = '0;
    din_b       = '0;
    din_valid_a = 1'b0;
    din_valid_b = 1'b0;
    areset      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 areset = 1'b0;
    @(posedge clk);
    #1;

    // Single 101 word, then back-to-back, then three words under backpressure.
    send(0, 8'h05); idle(0, 6);
    send(0, 8'h05); send(0, 8'h03); idle(0, 6);
    send(0, 8'h06); send(0, 8'h01); send(0, 8'h07); idle(0, 12);

    // LSB-first A1, then all zeros against an idle level of 1.
    send(1, 8'hA1); idle(1, 2);
    send(1, 8'h00); idle(1, 12);

    // Reset during bit 2 of FF with 5A sitting in the holding buffer.
    send(1, 8'hFF); send(1, 8'h5A);
    din_valid_b = 1'b0;
    @(posedge clk);
    #1;
    chk("b_pre_rst_x_valid", x_valid_b, 1'b1);
    chk("b_pre_rst_din_ready", din_ready_b, 1'b0);
    #2 areset = 1'b1;
    #1;
    chk("b_async_rst_x", x_b, IDLE_B);
    chk("b_async_rst_x_valid", x_valid_b, 1'b0);
    chk("b_async_rst_din_ready", din_ready_b, 1'b1);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    #1 areset = 1'b0;
    @(posedge clk);
    #1;
    idle(1, 14);

    // Randomized words and gaps on both instances concurrently.
    fork
      rand_run(0);
      rand_run(1);
    join

    for (int i = 0; i < 300 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d/%0d expected bits never emitted", q_a.size(), q_b.size());
    end
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
